// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file of the 5-stage MIPS pipeline.
// Two combinational read ports with write-first bypass; index 0 is hardwired zero.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic [DATA_W-1:0] readData,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] writeData
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic [DATA_W-1:0] wdata_s;
  logic              wr_en_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;

  // Write-back value select and effective write enable (writes to $zero dropped)
  always_comb begin
    wdata_s = {DATA_W{1'b0}};
    wr_en_s = 1'b0;
    if (MemtoReg) begin
      wdata_s = readData;
    end else begin
      wdata_s = ALUresult;
    end
    if (RegWrite && (writeReg != {ADDR_W{1'b0}})) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Register array: asynchronous clear, single write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[writeReg] <= wdata_s;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Read ports: zero register first, then same-cycle bypass, then array
  always_comb begin
    rd1_s = {DATA_W{1'b0}};
    rd2_s = {DATA_W{1'b0}};
    if (readReg1 == {ADDR_W{1'b0}}) begin
      rd1_s = {DATA_W{1'b0}};
    end else if (RegWrite && (writeReg == readReg1)) begin
      rd1_s = wdata_s;
    end else begin
      rd1_s = regs_r[readReg1];
    end
    if (readReg2 == {ADDR_W{1'b0}}) begin
      rd2_s = {DATA_W{1'b0}};
    end else if (RegWrite && (writeReg == readReg2)) begin
      rd2_s = wdata_s;
    end else begin
      rd2_s = regs_r[readReg2];
    end
  end

  assign readData1 = rd1_s;
  assign readData2 = rd2_s;
  assign writeData = wdata_s;

endmodule
